mem_stage: RTL

Memory-access stage of the 5-stage pipeline; sits directly downstream of the execute-stage ALU and consumes its 32-bit result as either a load/store address or a pass-through writeback value. Drives a req/ack data-memory port, aligns store data and byte strobes, and extracts and extends load data. Registers the MEM/WB outputs and back-pressures execute while an access is outstanding.

---
 rtl/mem_pkg.sv | 39 +++
 rtl/mem_stage_load_align.sv | 26 ++
 rtl/mem_stage.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: access sizes, exception codes,
// FSM states and the byte-strobe patterns used by stores.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_e;

    // The reserved size code 2'b11 is handled exactly like a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return STRB_BYTE << off;
            SZ_HALF: return STRB_HALF << off;
            default: return STRB_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load-data alignment: picks the addressed byte/half lane out of the read word
// and sign- or zero-extends it to 32 bits.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data = shifted;
        case (size)
            SZ_BYTE: data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_HALF: data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives the req/ack data port and registers MEM/WB.
// Optional ack watchdog enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [31:0]       ex_alu_result,
    input  logic [31:0]       ex_store_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    input  logic              flush,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic [1:0]        wb_exc,
    output logic              dbg_state
);

    // Handshake: execute hands over an op on a cycle with ex_valid && ex_ready;
    // the memory request (dmem_req and its payload) stays stable until the cycle
    // dmem_ack is seen high, and ack while dmem_req is low has no effect.
    state_e              state_q, state_d;
    logic                req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [1:0]          off_q, off_d, size_q, size_d;
    logic                uns_q, uns_d, load_q, load_d;
    logic [4:0]          rd_q, rd_d;
    logic                regw_q, regw_d, kill_q, kill_d;
    logic                wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d;
    logic [31:0]         wb_data_q, wb_data_d;
    logic [4:0]          wb_rd_q, wb_rd_d;
    logic [1:0]          wb_exc_q, wb_exc_d;
    logic [31:0]         load_val;
    logic                timeout;

    load_align u_load_align (
        .rdata       (dmem_rdata),
        .offset      (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (load_val)
    );

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts completed ACCESS cycles without ack; the last allowed one fires.
    assign timeout = (state_q == S_ACCESS) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == S_ACCESS && !dmem_ack && !timeout) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        off_d          = off_q;
        size_d         = size_q;
        uns_d          = uns_q;
        load_d         = load_q;
        rd_d           = rd_q;
        regw_d         = regw_q;
        kill_d         = kill_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = 1'b0;
        wb_exc_d       = EXC_NONE;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
        case (state_q)
            S_IDLE: begin
                if (ex_valid && !flush) begin
                    if (!(ex_mem_read || ex_mem_write)) begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = ex_alu_result;
                        wb_rd_d        = ex_rd;
                        wb_reg_write_d = ex_reg_write && (ex_rd != 5'd0);
                    end else if (is_misaligned(ex_size, ex_alu_result[1:0])) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_alu_result;
                        wb_rd_d    = ex_rd;
                        wb_exc_d   = EXC_MISALIGN;
                    end else begin
                        state_d = S_ACCESS;
                        req_d   = 1'b1;
                        we_d    = ex_mem_write;
                        addr_d  = {ex_alu_result[ADDR_W-1:2], 2'b00};
                        wstrb_d = ex_mem_write ? store_strobe(ex_size, ex_alu_result[1:0]) : 4'b0000;
                        case (ex_size)
                            SZ_BYTE: wdata_d = {4{ex_store_data[7:0]}};
                            SZ_HALF: wdata_d = {2{ex_store_data[15:0]}};
                            default: wdata_d = ex_store_data;
                        endcase
                        off_d  = ex_alu_result[1:0];
                        size_d = ex_size;
                        uns_d  = ex_unsigned;
                        load_d = ex_mem_read;
                        rd_d   = ex_rd;
                        regw_d = ex_mem_read && ex_reg_write && (ex_rd != 5'd0);
                        kill_d = 1'b0;
                    end
                end
            end
            S_ACCESS: begin
                if (flush) kill_d = 1'b1;
                if (dmem_ack || timeout) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    wstrb_d = 4'b0000;
                    kill_d  = 1'b0;
                    // A flush arriving on the ack cycle still kills the result.
                    if (!kill_q && !flush) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        if (dmem_ack) begin
                            wb_data_d      = load_q ? load_val : 32'h0;
                            wb_reg_write_d = regw_q;
                        end else begin
                            wb_exc_d = EXC_TIMEOUT;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= 32'h0;
            wstrb_q        <= 4'b0000;
            off_q          <= 2'b00;
            size_q         <= 2'b00;
            uns_q          <= 1'b0;
            load_q         <= 1'b0;
            rd_q           <= 5'd0;
            regw_q         <= 1'b0;
            kill_q         <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_exc_q       <= EXC_NONE;
            wb_data_q      <= 32'h0;
            wb_rd_q        <= 5'd0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            off_q          <= off_d;
            size_q         <= size_d;
            uns_q          <= uns_d;
            load_q         <= load_d;
            rd_q           <= rd_d;
            regw_q         <= regw_d;
            kill_q         <= kill_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_exc_q       <= wb_exc_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
        end
    end

    assign ex_ready     = (state_q == S_IDLE);
    assign dbg_state    = state_q;
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_wstrb   = wstrb_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_exc       = wb_exc_q;

endmodule
